// File: rtl/ctl_pkg.sv
// Shared encodings for the 65C02 interrupt/reset sequencer: vector-select codes and sequencer states.
package ctl_pkg;

  localparam logic [1:0] VEC_NONE = 2'b00;
  localparam logic [1:0] VEC_NMI  = 2'b01;
  localparam logic [1:0] VEC_RES  = 2'b10;
  localparam logic [1:0] VEC_IRQ  = 2'b11;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  // NMI outranks IRQ whenever both are requesting at an instruction boundary.
  function automatic logic [1:0] irq_vector(input logic nmi_pending);
    return nmi_pending ? VEC_NMI : VEC_IRQ;
  endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for an asynchronous active-low pin; idles high out of reset.
module pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic pin_s
);

  logic [STAGES-1:0] chain_d;
  logic [STAGES-1:0] chain_q;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], pin};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign pin_s = chain_q[STAGES-1];

endmodule

// File: rtl/int_ctl.sv
// Interrupt and reset sequencer: pin synchronisation, NMI edge capture, reset stretch,
// vector selection at instruction boundaries and WAI/STP stalling of the core.
module int_ctl
  import ctl_pkg::*;
#(
  parameter int RST_CYCLES  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       sync,
  input  logic       I,
  input  logic       wai,
  input  logic       stp,
  output logic       core_reset,
  output logic       int_req,
  output logic [1:0] vec_sel,
  output logic       rdy
);

  localparam int              CNT_W    = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic irq_s;
  logic nmi_s;
  logic nmi_fall;
  logic nmi_clr;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             nmi_prev_d, nmi_prev_q;
  logic             nmi_pend_d, nmi_pend_q;
  logic             core_reset_d, core_reset_q;
  logic [1:0]       vec_sel_d, vec_sel_q;
  logic             rdy_d, rdy_q;

  pin_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (irq_n),
    .pin_s (irq_s)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (nmi_n),
    .pin_s (nmi_s)
  );

  assign nmi_fall = nmi_prev_q & ~nmi_s;

  // I masking happens here; the controller sees an already-qualified request.
  assign int_req = (state_q == ST_RUN) & (nmi_pend_q | (~irq_s & ~I));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_reset_d = core_reset_q;
    vec_sel_d    = vec_sel_q;
    rdy_d        = rdy_q;
    nmi_clr      = 1'b0;
    nmi_prev_d   = nmi_s;

    case (state_q)
      ST_RST: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = ST_RUN;
          core_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (sync) begin
          vec_sel_d = int_req ? irq_vector(nmi_pend_q) : VEC_NONE;
          nmi_clr   = nmi_pend_q;
        end else begin
          vec_sel_d = vec_sel_q;
        end
        if (stp) begin
          state_d = ST_STOP;
          rdy_d   = 1'b0;
        end else if (wai) begin
          state_d = ST_WAIT;
          rdy_d   = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      // Wake ignores I: a masked IRQ still resumes the core, it just is not taken.
      ST_WAIT: begin
        if (stp) begin
          state_d = ST_STOP;
        end else if (nmi_pend_q | ~irq_s) begin
          state_d = ST_RUN;
          rdy_d   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STOP: begin
        state_d = ST_STOP;
      end
      default: begin
        state_d      = ST_RST;
        core_reset_d = 1'b1;
        rdy_d        = 1'b1;
      end
    endcase

    // A fresh edge wins over a same-cycle clear so it is never dropped.
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RST;
      cnt_q        <= '0;
      nmi_prev_q   <= 1'b1;
      nmi_pend_q   <= 1'b0;
      core_reset_q <= 1'b1;
      vec_sel_q    <= VEC_RES;
      rdy_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nmi_prev_q   <= nmi_prev_d;
      nmi_pend_q   <= nmi_pend_d;
      core_reset_q <= core_reset_d;
      vec_sel_q    <= vec_sel_d;
      rdy_q        <= rdy_d;
    end
  end

  assign core_reset = core_reset_q;
  assign vec_sel    = vec_sel_q;
  assign rdy        = rdy_q;

endmodule

// File: doc/int_ctl.md
Name: int_ctl

Overview:
- Interrupt and reset sequencer in front of the 65C02 microcode controller.
- Synchronises the external IRQ/NMI pins and edge-detects NMI.
- Stretches reset to the core for a fixed number of cycles.
- Drives the controller's interrupt request and a vector-select code sampled at instruction boundaries.
- Implements the WAI/STP low-power states by dropping RDY to the core.

Parameters:
RST_CYCLES, 7, cycles core_reset stays high after reset deasserts (>=1)
SYNC_STAGES, 2, flops in each pin synchroniser (>=2)

Ports:
clk  in  1  core clock, all logic on rising edge
reset  in  1  synchronous, active-low (0 = reset)
irq_n  in  1  external IRQ pin, asynchronous, level, active-low
nmi_n  in  1  external NMI pin, asynchronous, falling-edge, active-low
sync  in  1  from controller: high in the cycle a new opcode is decoded
I  in  1  processor I flag
wai  in  1  one-cycle pulse: core decoded WAI
stp  in  1  one-cycle pulse: core decoded STP
core_reset  out  1  reset to controller, active-high
int_req  out  1  interrupt request to controller, already masked
vec_sel  out  2  00 none, 01 NMI ($FFFA), 10 RES ($FFFC), 11 IRQ ($FFFE)
rdy  out  1  core advance enable; 0 stalls the core

Behaviour:
Reset and outputs:
- reset=0 at a clock edge: state=RST, counter=0, nmi_pend=0, all synchroniser flops=1.
- Reset outputs: core_reset=1, int_req=0, vec_sel=10, rdy=1.
- reset=0 in any state (including WAIT/STOP, mid-count) forces the same values on the next edge.

Synchronisers:
- irq_s and nmi_s are SYNC_STAGES-deep flop chains.
- Input-to-internal latency is SYNC_STAGES cycles.
- nmi_prev holds the previous nmi_s. nmi_fall = nmi_prev & ~nmi_s.

State machine: RST, RUN, WAIT, STOP.
- RST:
  - Counter increments each cycle with reset=1.
  - Counter width is clog2(RST_CYCLES+1).
  - At count==RST_CYCLES-1, go to RUN. core_reset falls exactly RST_CYCLES cycles after the first cycle with reset=1.
  - vec_sel stays 10 until the first sync in RUN, then follows the rules below.
- RUN:
  - int_req = nmi_pend | (~irq_s & ~I), combinational from registered state.
  - The controller must not apply I masking again (its I input is tied 0 in this configuration).
- Vector latch on sync:
  - sync & int_req: register vec_sel = 01 if nmi_pend, else 11.
  - sync & ~int_req: register vec_sel = 00.
  - vec_sel is held between syncs.
- NMI pending:
  - nmi_pend is set by nmi_fall and cleared by (sync & nmi_pend & state==RUN).
  - A set and a clear in the same cycle leaves it set, so the new edge is not lost.
  - A held-low NMI produces exactly one pending event.
- IRQ:
  - IRQ is level, not latched.
  - If irq_n returns high before a sync, no interrupt is taken.
- WAI:
  - A wai pulse in RUN goes to WAIT. rdy=0 from the next cycle.
  - WAIT exits to RUN when nmi_pend | ~irq_s, regardless of I. rdy=1 in the cycle after the exit condition.
  - int_req is masked per the RUN rule once the state is back in RUN, so with I=1 an IRQ resumes the core without being taken.
- STP:
  - A stp pulse in RUN or WAIT goes to STOP. rdy=0. Only reset leaves STOP.
  - nmi_pend may still be set in STOP but has no effect.
- Priority and ignored inputs:
  - Simultaneous stp and wai: stp wins.
  - NMI beats IRQ at sync.
  - wai, stp and sync are ignored in RST.
  - sync is ignored in WAIT/STOP (core is stalled).
- Timing: all outputs are registered except int_req, which is a two-term function of flops and I.

Decomposition:
- Shared package ctl_pkg holds:
  - vec_sel encodings VEC_NONE/VEC_NMI/VEC_RES/VEC_IRQ.
  - State enum ST_RST/ST_RUN/ST_WAIT/ST_STOP.
- The controller and address logic import ctl_pkg for vector decoding.
- One sub-module is natural: pin_sync (SYNC_STAGES-deep flop chain, reset value 1), instantiated twice.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, then release with RST_CYCLES=7 -> core_reset=1 for exactly 7 cycles after release, then 0. vec_sel=10 until the first sync, then 00 with pins idle.
2. NMI edge: drop nmi_n and hold it low for 50 cycles, pulsing sync every 4 cycles.
   - nmi_pend sets 3 cycles after the fall.
   - int_req=1 until the next sync, when vec_sel=01.
   - int_req=0 afterwards; only one NMI is taken.
3. IRQ masking: irq_n=0 with I=1 -> int_req=0 and vec_sel=00 at each sync. Drop I to 0 -> int_req=1; the next sync gives vec_sel=11.
4. Priority and collision: NMI falling edge and irq_n=0 (I=0) pending together; sync -> vec_sel=01, and IRQ gives 11 at the following sync. Second NMI edge landing in the same cycle as the clearing sync -> nmi_pend remains 1.
5. WAI: wai pulse with I=1 -> rdy=0 next cycle. Drop irq_n -> rdy=1 SYNC_STAGES+1 cycles later, with int_req=0.
6. STP and reset recovery:
   - stp pulse -> rdy=0.
   - IRQ and NMI toggles leave rdy=0.
   - reset=0 for 1 cycle -> state RST, core_reset=1, rdy=1, vec_sel=10, nmi_pend=0.
   - Simultaneous wai and stp in RUN -> STOP.
